// File: rtl/trap_ctrl.sv
// Machine-mode trap sequencer: on exception, interrupt or mret it takes the CSR port from the pipeline and
// writes mepc/mcause(/mtval), then reads mtvec or mepc to redirect fetch.
// Compile option: define TRAP_CTRL_MTVAL_EN to include the mtval write (TVAL state).
module trap_ctrl (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_exc_valid,
    input  logic [4:0]  i_exc_cause,
    input  logic [31:0] i_exc_pc,
    input  logic [31:0] i_exc_tval,
    input  logic        i_mret,
    input  logic        i_irq,
    input  logic        i_pipe_csr_we,
    input  logic        i_pipe_csr_re,
    input  logic [3:0]  i_pipe_funct3,
    input  logic [11:0] i_pipe_csr_addr,
    input  logic [31:0] i_pipe_csr_wdata,
    output logic        o_csr_we,
    output logic        o_csr_re,
    output logic [3:0]  o_csr_funct3,
    output logic [11:0] o_csr_addr,
    output logic [31:0] o_csr_data,
    input  logic [31:0] i_csr_rdata,
    output logic [31:0] o_pipe_csr_rdata,
    output logic        o_stall,
    output logic        o_flush,
    output logic        o_redirect_valid,
    output logic [31:0] o_redirect_pc
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_EPC,
        S_CAUSE,
        S_TVAL,
        S_TVEC,
        S_RET
    } state_t;

    localparam logic [3:0]  FUNCT3_CSRRW = 4'b0001;
    localparam logic [11:0] ADDR_MTVEC   = 12'h305;
    localparam logic [11:0] ADDR_MEPC    = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE  = 12'h342;
    localparam logic [11:0] ADDR_MTVAL   = 12'h343;
    localparam logic [31:0] CAUSE_MEI    = 32'h8000_000B;

    state_t      state_q, state_d;
    logic [31:0] pc_q, cause_q, tval_q;
    logic        take_exc, take_mret, take_irq;

    // Acceptance priority: exception > mret > interrupt, only from IDLE.
    always_comb begin
        take_exc  = (state_q == S_IDLE) && i_exc_valid;
        take_mret = (state_q == S_IDLE) && !i_exc_valid && i_mret;
        take_irq  = (state_q == S_IDLE) && !i_exc_valid && !i_mret && i_irq;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            cause_q <= '0;
            tval_q  <= '0;
        end else begin
            state_q <= state_d;
            if (take_exc) begin
                pc_q    <= i_exc_pc;
                cause_q <= {1'b0, 26'b0, i_exc_cause};
                tval_q  <= i_exc_tval;
            end else if (take_irq) begin
                pc_q    <= i_exc_pc;
                cause_q <= CAUSE_MEI;
                tval_q  <= '0;
            end
        end
    end

    // NOTE: every output and state_d gets a default first, so no path can infer a latch.
    always_comb begin
        state_d          = state_q;
        o_csr_we         = 1'b0;
        o_csr_re         = 1'b0;
        o_csr_funct3     = '0;
        o_csr_addr       = '0;
        o_csr_data       = '0;
        o_pipe_csr_rdata = '0;
        o_stall          = (state_q != S_IDLE);
        o_flush          = 1'b0;
        o_redirect_valid = 1'b0;
        o_redirect_pc    = '0;

        case (state_q)
            S_IDLE: begin
                // Reset gating keeps the input-driven IDLE outputs at 0 while reset is low.
                if (i_rst) begin
                    if (take_exc || take_irq) begin
                        o_flush = 1'b1;
                        state_d = S_EPC;
                    end else if (take_mret) begin
                        o_flush = 1'b1;
                        state_d = S_RET;
                    end else begin
                        o_csr_we         = i_pipe_csr_we;
                        o_csr_re         = i_pipe_csr_re;
                        o_csr_funct3     = i_pipe_funct3;
                        o_csr_addr       = i_pipe_csr_addr;
                        o_csr_data       = i_pipe_csr_wdata;
                        o_pipe_csr_rdata = i_csr_rdata;
                    end
                end
            end
            S_EPC: begin
                o_csr_we     = 1'b1;
                o_csr_funct3 = FUNCT3_CSRRW;
                o_csr_addr   = ADDR_MEPC;
                o_csr_data   = pc_q;
                state_d      = S_CAUSE;
            end
            S_CAUSE: begin
                o_csr_we     = 1'b1;
                o_csr_funct3 = FUNCT3_CSRRW;
                o_csr_addr   = ADDR_MCAUSE;
                o_csr_data   = cause_q;
`ifdef TRAP_CTRL_MTVAL_EN
                state_d      = S_TVAL;
`else
                state_d      = S_TVEC;
`endif
            end
`ifdef TRAP_CTRL_MTVAL_EN
            S_TVAL: begin
                o_csr_we     = 1'b1;
                o_csr_funct3 = FUNCT3_CSRRW;
                o_csr_addr   = ADDR_MTVAL;
                o_csr_data   = tval_q;
                state_d      = S_TVEC;
            end
`endif
            S_TVEC: begin
                o_csr_re         = 1'b1;
                o_csr_addr       = ADDR_MTVEC;
                o_redirect_valid = 1'b1;
                o_redirect_pc    = {i_csr_rdata[31:2], 2'b00};
                state_d          = S_IDLE;
            end
            S_RET: begin
                o_csr_re         = 1'b1;
                o_csr_addr       = ADDR_MEPC;
                o_redirect_valid = 1'b1;
                o_redirect_pc    = {i_csr_rdata[31:2], 2'b00};
                state_d          = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

`ifndef TRAP_CTRL_MTVAL_EN
    logic unused_tval;
    assign unused_tval = ^tval_q;
`endif

endmodule
